// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg
// Shared definitions for the fuzzy risk estimator front end.
//   DW_DEFAULT / NUM_CH_DEFAULT : default byte width and channels per frame
//   loader_state_e              : input loader FSM states
//   frame_t                     : one committed frame, channel 0 in the low byte
package fuzzy_pkg;

  localparam int DW_DEFAULT     = 8;
  localparam int NUM_CH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } loader_state_e;

  typedef logic [NUM_CH_DEFAULT-1:0][DW_DEFAULT-1:0] frame_t;

endpackage

// File: rtl/ss_sync_edge.sv
// ss_sync_edge
// Brings an asynchronous pin strobe into the clock domain and flags its
// rising edges. A strobe held high produces a single rise pulse.
// Ports:
//   clk      in  : clock
//   rst_n    in  : asynchronous active-low reset
//   async_in in  : raw strobe from the pin
//   rise     out : one-cycle pulse per rising edge of async_in
module ss_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchronizer chain plus one extra flop holding the previous synchronized
  // level, so the edge detector only ever looks at settled values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/fuzzy_input_loader.sv
// fuzzy_input_loader
// Captures one byte from data_bus per rising edge of the asynchronous sample
// strobe ss, assembles NUM_CH bytes into a frame and hands the frame over a
// valid/ready interface in one step. Flags inter-byte timeouts and overruns.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ss           : asynchronous sample strobe (one byte per rising edge)
//   data_bus     : byte value, stable while the strobe is being sampled
//   ch_data      : committed frame, channel 0 in bits [DW-1:0]
//   out_valid    : ch_data holds an unconsumed frame
//   out_ready    : consumer accepts the frame when out_valid & out_ready
//   busy         : partial frame in progress
//   timeout_err  : one-cycle pulse when a partial frame is discarded
//   overrun      : one-cycle pulse when an unconsumed frame is overwritten
module fuzzy_input_loader
  import fuzzy_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int NUM_CH      = NUM_CH_DEFAULT,
  parameter int TIMEOUT_CYC = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss,
  input  logic [DW-1:0]        data_bus,
  output logic [NUM_CH*DW-1:0] ch_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 overrun
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  loader_state_e state, next_state;

  logic                        rise;
  logic [IDX_W-1:0]            idx;
  logic [CNT_W-1:0]            tmo_cnt;
  logic                        tmo_hit;
  logic [NUM_CH-1:0][DW-1:0]   shadow;

  logic capture_first;
  logic capture_next;
  logic tmo_fire;
  logic commit_now;

  ss_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ss_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ss),
    .rise     (rise)
  );

  assign tmo_hit = (tmo_cnt == TIMEOUT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A rise arriving exactly when the timeout expires restarts the frame with
  // this byte as channel 0 instead of signalling an error.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (rise) next_state = COLLECT;
      end
      COLLECT: begin
        if (rise) begin
          if (!tmo_hit && idx == LAST_IDX) next_state = COMMIT;
          else                             next_state = COLLECT;
        end else if (tmo_hit) begin
          next_state = IDLE;
        end
      end
      COMMIT: begin
        next_state = rise ? COLLECT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // capture_first starts a new frame at channel 0, capture_next appends at idx.
  always_comb begin
    capture_first = 1'b0;
    capture_next  = 1'b0;
    tmo_fire      = 1'b0;
    commit_now    = 1'b0;
    unique case (state)
      IDLE: begin
        capture_first = rise;
      end
      COLLECT: begin
        capture_first = rise & tmo_hit;
        capture_next  = rise & ~tmo_hit;
        tmo_fire      = ~rise & tmo_hit;
      end
      COMMIT: begin
        capture_first = rise;
        commit_now    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state == COLLECT);

  // Datapath: shadow bytes, channel index, idle counter and the output
  // register. The counter runs only while a partial frame waits for bytes.
  // A commit always wins over a handshake on the same edge, so out_valid
  // stays high when the consumer takes the old frame as a new one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      tmo_cnt     <= '0;
      shadow      <= '0;
      ch_data     <= '0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      overrun     <= commit_now & out_valid & ~out_ready;

      if (capture_first) begin
        shadow[0] <= data_bus;
        idx       <= IDX_W'(1);
      end else if (capture_next) begin
        shadow[idx] <= data_bus;
        idx         <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else if (tmo_fire) begin
        idx <= '0;
      end

      if (capture_first || capture_next || next_state != COLLECT) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (commit_now) begin
        ch_data   <= shadow;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fuzzy_input_loader.sv
// tb_fuzzy_input_loader
// Self-checking bench for fuzzy_input_loader: directed scenarios followed by
// randomized strobe traffic, compared every cycle against a frame-level model.
module tb_fuzzy_input_loader;

  localparam int DW          = 8;
  localparam int NUM_CH      = 4;
  localparam int TIMEOUT_CYC = 1023;
  localparam int SYNC_STAGES = 2;
  localparam int FW          = DW * NUM_CH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ss;
  logic [DW-1:0] data_bus;
  logic [FW-1:0] ch_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          timeout_err;
  logic          overrun;

  fuzzy_input_loader #(
    .DW          (DW),
    .NUM_CH      (NUM_CH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ss          (ss),
    .data_bus    (data_bus),
    .ch_data     (ch_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: bytes keyed by the clock edge at which they must be
  // captured, the bytes of the frame being assembled, and the expected outputs.
  logic [DW-1:0] cap_map [int];
  logic [DW-1:0] partial [$];
  int            last_cap    = 0;
  bit            commit_pend = 1'b0;
  logic [FW-1:0] pend_frame  = '0;
  logic [FW-1:0] m_data      = '0;
  bit            m_valid     = 1'b0;
  bit            m_tmo       = 1'b0;
  bit            m_ovr       = 1'b0;

  int vcnt = 0, tcnt = 0, ocnt = 0;
  int tmo_cyc = 0, vfirst = 0, last_sched = 0, cap2 = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One byte per call: strobe high for hi cycles, low for lo cycles. A strobe
  // rising between edges k-1 and k is captured at edge k+2.
  task automatic applyStimulus(input logic [DW-1:0] b, input int hi, input int lo, input bit rdy);
    out_ready  = rdy;
    data_bus   = b;
    ss         = 1'b1;
    last_sched = cyc + 3;
    cap_map[cyc + 3] = b;
    repeat (hi) @(negedge clk);
    ss = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Frame-level model, advanced once per clock edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cap_map.delete();
      partial.delete();
      commit_pend = 1'b0;
      m_data      = '0;
      m_valid     = 1'b0;
      m_tmo       = 1'b0;
      m_ovr       = 1'b0;
    end else begin
      cyc++;
      m_tmo = 1'b0;
      m_ovr = 1'b0;
      if (commit_pend) begin
        m_ovr       = m_valid && !out_ready;
        m_valid     = 1'b1;
        m_data      = pend_frame;
        commit_pend = 1'b0;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (cap_map.exists(cyc)) begin
        if (partial.size() > 0 && cyc - last_cap == TIMEOUT_CYC + 1) partial.delete();
        partial.push_back(cap_map[cyc]);
        cap_map.delete(cyc);
        last_cap = cyc;
        if (partial.size() == NUM_CH) begin
          for (int i = 0; i < NUM_CH; i++) pend_frame[i*DW +: DW] = partial[i];
          commit_pend = 1'b1;
          partial.delete();
        end
      end else if (partial.size() > 0 && cyc - last_cap == TIMEOUT_CYC + 1) begin
        m_tmo = 1'b1;
        partial.delete();
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("ch_data",     64'(ch_data),     64'(m_data));
      checkOutput("out_valid",   64'(out_valid),   64'(m_valid));
      checkOutput("busy",        64'(busy),        64'(partial.size() > 0));
      checkOutput("timeout_err", 64'(timeout_err), 64'(m_tmo));
      checkOutput("overrun",     64'(overrun),     64'(m_ovr));
      if (out_valid === 1'b1) begin
        if (vcnt == 0) vfirst = cyc;
        vcnt++;
      end
      if (timeout_err === 1'b1) begin
        tcnt++;
        tmo_cyc = cyc;
      end
      if (overrun === 1'b1) ocnt++;
    end
  end

  initial begin
    int hi, lo, sel;
    rst_n     = 1'b0;
    ss        = 1'b0;
    data_bus  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ch_data", 64'(ch_data), 64'(0));
    checkOutput("rst_valid",   64'(out_valid), 64'(0));
    checkOutput("rst_busy",    64'(busy), 64'(0));
    checkOutput("rst_flags",   64'({timeout_err, overrun}), 64'(0));
    chk_en = 1'b1;

    $display("[TB] basic frame");
    vcnt = 0; tcnt = 0; ocnt = 0;
    applyStimulus(8'h12, 4, 4, 1'b1);
    applyStimulus(8'h34, 4, 4, 1'b1);
    applyStimulus(8'h56, 4, 4, 1'b1);
    applyStimulus(8'h78, 4, 4, 1'b1);
    checkOutput("basic_data",  64'(ch_data), 64'(32'h78563412));
    checkOutput("basic_vcnt",  64'(vcnt), 64'(1));
    checkOutput("basic_lat",   64'(vfirst - (last_sched - 2)), 64'(3));
    checkOutput("basic_flags", 64'(tcnt + ocnt), 64'(0));

    $display("[TB] timeout");
    tcnt = 0;
    applyStimulus(8'hB1, 3, 3, 1'b1);
    applyStimulus(8'hB2, 3, 3, 1'b1);
    cap2 = last_sched;
    repeat (1100) @(negedge clk);
    checkOutput("tmo_count", 64'(tcnt), 64'(1));
    checkOutput("tmo_delay", 64'(tmo_cyc - cap2), 64'(TIMEOUT_CYC + 1));
    checkOutput("tmo_busy",  64'(busy), 64'(0));
    applyStimulus(8'hA1, 2, 3, 1'b1);
    applyStimulus(8'hA2, 2, 3, 1'b1);
    applyStimulus(8'hA3, 2, 3, 1'b1);
    applyStimulus(8'hA4, 2, 3, 1'b1);
    checkOutput("tmo_next_data", 64'(ch_data), 64'(32'hA4A3A2A1));

    $display("[TB] overrun");
    ocnt = 0;
    for (int i = 1; i <= 8; i++) applyStimulus(DW'(i), 2, 2, 1'b0);
    checkOutput("ovr_count", 64'(ocnt), 64'(1));
    checkOutput("ovr_data",  64'(ch_data), 64'(32'h08070605));
    checkOutput("ovr_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_drain", 64'(out_valid), 64'(0));

    $display("[TB] ready on commit edge");
    ocnt = 0;
    for (int i = 1; i <= 4; i++) applyStimulus(DW'(8'hC0 + i), 2, 2, 1'b0);
    for (int i = 1; i <= 3; i++) applyStimulus(DW'(8'hD0 + i), 2, 2, 1'b0);
    out_ready  = 1'b0;
    data_bus   = 8'hD4;
    ss         = 1'b1;
    last_sched = cyc + 3;
    cap_map[cyc + 3] = 8'hD4;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rdy_commit_ovr",   64'(ocnt), 64'(0));
    checkOutput("rdy_commit_valid", 64'(out_valid), 64'(1));
    checkOutput("rdy_commit_data",  64'(ch_data), 64'(32'hD4D3D2D1));
    ss = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hE1, 2, 2, 1'b1);
    applyStimulus(8'hE2, 2, 2, 1'b1);
    applyStimulus(8'hE3, 2, 2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_data",  64'(ch_data), 64'(0));
    checkOutput("mid_rst_valid", 64'(out_valid), 64'(0));
    checkOutput("mid_rst_busy",  64'(busy), 64'(0));
    checkOutput("mid_rst_flags", 64'({timeout_err, overrun}), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'hF1, 2, 2, 1'b1);
    applyStimulus(8'hF2, 2, 2, 1'b1);
    applyStimulus(8'hF3, 2, 2, 1'b1);
    applyStimulus(8'hF4, 2, 2, 1'b1);
    checkOutput("post_rst_data", 64'(ch_data), 64'(32'hF4F3F2F1));

    $display("[TB] long strobe");
    vcnt = 0;
    for (int i = 0; i < 4; i++) applyStimulus(8'h5A, 20, 4, 1'b1);
    checkOutput("long_ss_data", 64'(ch_data), 64'(32'h5A5A5A5A));
    checkOutput("long_ss_vcnt", 64'(vcnt), 64'(1));
    checkOutput("long_ss_busy", 64'(busy), 64'(0));

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      hi  = $urandom_range(2, 6);
      lo  = $urandom_range(2, 6);
      sel = $urandom_range(0, 15);
      if (sel == 0)      lo = TIMEOUT_CYC + 1 - hi;
      else if (sel == 1) lo = TIMEOUT_CYC - hi;
      else if (sel == 2) lo = TIMEOUT_CYC + 2 - hi;
      applyStimulus(DW'($urandom), hi, lo, 1'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fuzzy_input_loader.md
# fuzzy_input_loader

Upstream front end of the fuzzy risk estimator. It captures bytes from the shared 8-bit data bus on rising edges of the asynchronous sample strobe `ss` and assembles `NUM_CH` consecutive bytes into one input frame (one byte per crisp sensor input). It hands each complete frame atomically to the fuzzification stage over a valid/ready handshake, and flags inter-byte timeouts and frame overruns.

## Interface
Parameters:
- `DW` = 8: width of each channel byte and of `data_bus`.
- `NUM_CH` = 4: bytes per frame (≥2).
- `TIMEOUT_CYC` = 1023: idle cycles allowed between bytes inside a frame.
- `SYNC_STAGES` = 2: flops in the `ss` synchronizer (≥2).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ss` in 1: sample strobe from the pin, asynchronous; a rising edge means one byte.
- `data_bus` in DW: byte value; the host holds it stable from `ss` rise until `SYNC_STAGES+2` cycles later.
- `ch_data` out NUM_CH*DW: committed frame; channel 0 is in bits [DW-1:0].
- `out_valid` out 1: `ch_data` holds an unconsumed frame.
- `out_ready` in 1: consumer accepts the frame when `out_valid & out_ready`.
- `busy` out 1: a partial frame is in progress (state COLLECT).
- `timeout_err` out 1: one-cycle pulse when a partial frame is discarded.
- `overrun` out 1: one-cycle pulse when an unconsumed frame is overwritten.

## Operation
- `ss` passes through `SYNC_STAGES` flops. `rise` = last sync stage high and a delayed copy of it low.
- `ss` high and low times must each be ≥2 cycles. A held-high `ss` gives exactly one `rise`.
- State machine:
  - IDLE: `idx`=0. On `rise`: shadow[0] ← `data_bus`, `idx` ← 1, go to COLLECT.
  - COLLECT: on `rise`: shadow[`idx`] ← `data_bus`. If `idx`=NUM_CH-1, go to COMMIT; otherwise `idx`+1.
  - COLLECT timeout: a counter clears on every capture and increments otherwise. When it reaches TIMEOUT_CYC: pulse `timeout_err`, `idx` ← 0, go to IDLE. Shadow contents are don't-care.
  - COMMIT (1 cycle): `ch_data` ← shadow, `out_valid` ← 1, then go to IDLE. A `rise` in COMMIT is captured as channel 0 of the next frame and the next state is COLLECT.
- Handshake:
  - `out_valid` falls on the cycle after `out_valid & out_ready`, unless a commit occurs on that same edge.
  - Commit with `out_valid`=1 and `out_ready`=0: `ch_data` is overwritten, `overrun` pulses, `out_valid` stays 1.
  - Commit with `out_valid`=1 and `out_ready`=1: the old frame is consumed and the new one loaded, `out_valid` stays 1, no `overrun`.
  - `ch_data` changes only at a commit.
- `busy` = (state == COLLECT).

## Timing
- Reset values: `ch_data`=0, `out_valid`=0, `busy`=0, `timeout_err`=0, `overrun`=0. Also: state IDLE, `idx`=0, counter 0, sync flops 0.
- `ss` rises between edges k-1 and k: `rise` is high in the cycle after edge k+SYNC_STAGES-1. Capture happens at edge k+SYNC_STAGES. With defaults, capture is at edge k+2.
- Final byte: captured at edge k+2, COMMIT during the next cycle, `out_valid` and new `ch_data` visible after edge k+3.
- Timeout: `timeout_err` is high in the cycle after the counter reaches TIMEOUT_CYC, i.e. TIMEOUT_CYC+1 cycles after the last capture. A `rise` on the same edge as the timeout wins: the byte is captured as channel 0 and there is no error pulse.
- Asynchronous reset mid-frame discards the partial frame and the committed frame immediately. The first `rise` after release is channel 0.

## Structure
- Shared package `fuzzy_pkg`:
  - `DW`, `NUM_CH` defaults.
  - Loader state enum {IDLE, COLLECT, COMMIT}.
  - Frame typedef: array of NUM_CH × DW bytes.
- Sub-module `ss_sync_edge`: parameterized synchronizer plus rise detector, outputs `rise`. It is reused for any later pin strobes.
- The FSM, shadow registers, timeout counter and output register stay in `fuzzy_input_loader`.

## Test plan
- Bytes 0x12, 0x34, 0x56, 0x78, `ss` 4 high / 4 low cycles, `out_ready`=1 → `ch_data`=0x78563412, `out_valid` high for 1 cycle starting 3 edges after the last `ss` rise; no flags.
- 2 bytes, then `ss` idle for 1100 cycles → `timeout_err` pulses once, 1024 cycles after the 2nd capture, and `busy` drops. A following 4-byte frame 0xA1..0xA4 → `ch_data`=0xA4A3A2A1.
- `out_ready`=0, two full frames (0x01020304 then 0x05060708 in byte order) → `overrun` pulses at the 2nd commit, `ch_data`=0x08070605, `out_valid` stays 1. Then `out_ready`=1 → `out_valid` falls the next cycle.
- `out_ready` asserted exactly on a commit edge while `out_valid`=1 → no `overrun`, `out_valid` stays 1, `ch_data` holds the new frame.
- `rst_n` pulsed low after 3 of 4 bytes → all outputs 0 immediately. A following 4-byte frame is assembled from channel 0 correctly.
- `ss` held high for 20 cycles with `data_bus`=0x5A, repeated 4 times → exactly 4 captures, `ch_data`=0x5A5A5A5A.
